// File: rtl/vga_timing_pkg.sv
// Shared 640x480@60 raster constants and the coordinate type used by every
// display block that consumes x/y from vga_timing_gen.
package vga_timing_pkg;

  localparam int H_DISPLAY = 32'd640;
  localparam int H_FRONT   = 32'd16;
  localparam int H_SYNC    = 32'd96;
  localparam int H_BACK    = 32'd48;
  localparam int V_DISPLAY = 32'd480;
  localparam int V_FRONT   = 32'd10;
  localparam int V_SYNC    = 32'd2;
  localparam int V_BACK    = 32'd33;

  localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

  localparam int COORD_W = 32'd10;
  typedef logic [COORD_W-1:0] coord_t;

  typedef struct packed {
    logic hsync;
    logic vsync;
    logic video_on;
  } sync_t;

  function automatic logic in_range(input coord_t v, input coord_t lo, input coord_t hi);
    return (v >= lo) && (v <= hi);
  endfunction

endpackage

// File: rtl/pixel_tick_div.sv
// Divides the system clock down to a registered one-clock pixel enable,
// first pulse CLK_DIV clocks after reset release.
module pixel_tick_div #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  output logic p_tick
);

  localparam int CW = $clog2(CLK_DIV);
  localparam logic [CW-1:0] CNT_MAX = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt_r;
  logic          tick_r;

  // wrap counter; tick is registered from the terminal count
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r  <= '0;
      tick_r <= 1'b0;
    end else begin
      tick_r <= (cnt_r == CNT_MAX);
      if (cnt_r == CNT_MAX) begin
        cnt_r <= '0;
      end else begin
        cnt_r <= cnt_r + 1'b1;
      end
    end
  end

  assign p_tick = tick_r;

endmodule

// File: rtl/vga_timing_gen.sv
// Raster scan generator: x/y, video_on, active-low syncs and frame_start.
// Define VGA_PIPE_EN to delay hsync/vsync/video_on by two clocks.
module vga_timing_gen #(
  parameter int CLK_DIV   = 4,
  parameter int H_DISPLAY = vga_timing_pkg::H_DISPLAY,
  parameter int H_FRONT   = vga_timing_pkg::H_FRONT,
  parameter int H_SYNC    = vga_timing_pkg::H_SYNC,
  parameter int H_BACK    = vga_timing_pkg::H_BACK,
  parameter int V_DISPLAY = vga_timing_pkg::V_DISPLAY,
  parameter int V_FRONT   = vga_timing_pkg::V_FRONT,
  parameter int V_SYNC    = vga_timing_pkg::V_SYNC,
  parameter int V_BACK    = vga_timing_pkg::V_BACK
) (
  input  logic                   clk,
  input  logic                   rst_n,
  output logic                   p_tick,
  output vga_timing_pkg::coord_t x,
  output vga_timing_pkg::coord_t y,
  output logic                   video_on,
  output logic                   hsync,
  output logic                   vsync,
  output logic                   frame_start
);

  import vga_timing_pkg::*;

  localparam int H_TOT = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOT = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

  localparam coord_t H_LAST   = coord_t'(H_TOT - 1);
  localparam coord_t V_LAST   = coord_t'(V_TOT - 1);
  localparam coord_t H_VIS    = coord_t'(H_DISPLAY);
  localparam coord_t V_VIS    = coord_t'(V_DISPLAY);
  localparam coord_t HS_FIRST = coord_t'(H_DISPLAY + H_FRONT);
  localparam coord_t HS_LAST  = coord_t'(H_DISPLAY + H_FRONT + H_SYNC - 1);
  localparam coord_t VS_FIRST = coord_t'(V_DISPLAY + V_FRONT);
  localparam coord_t VS_LAST  = coord_t'(V_DISPLAY + V_FRONT + V_SYNC - 1);

  localparam sync_t DEC_RST = '{hsync: 1'b1, vsync: 1'b1, video_on: 1'b1};

  if (H_TOT > 1024 || V_TOT > 1024 || CLK_DIV < 2) begin : g_bad_params
    $error("vga_timing_gen: totals must fit 10-bit counters and CLK_DIV must be >= 2");
  end

  logic   p_tick_s;
  coord_t x_r;
  coord_t y_r;
  coord_t x_next_s;
  coord_t y_next_s;
  logic   wrap_s;
  sync_t  dec_next_s;
  sync_t  dec_r;
  logic   frame_start_r;

  pixel_tick_div #(.CLK_DIV(CLK_DIV)) u_tick (
    .clk    (clk),
    .rst_n  (rst_n),
    .p_tick (p_tick_s)
  );

  // next-state counters; decode looks at the next state so it lands with x/y
  always_comb begin
    x_next_s = x_r;
    y_next_s = y_r;
    wrap_s   = 1'b0;
    if (p_tick_s) begin
      if (x_r == H_LAST) begin
        x_next_s = '0;
        if (y_r == V_LAST) begin
          y_next_s = '0;
          wrap_s   = 1'b1;
        end else begin
          y_next_s = y_r + 1'b1;
        end
      end else begin
        x_next_s = x_r + 1'b1;
      end
    end else begin
      x_next_s = x_r;
    end
    dec_next_s.hsync    = !in_range(x_next_s, HS_FIRST, HS_LAST);
    dec_next_s.vsync    = !in_range(y_next_s, VS_FIRST, VS_LAST);
    dec_next_s.video_on = (x_next_s < H_VIS) && (y_next_s < V_VIS);
  end

  // coordinate and decode registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_r           <= '0;
      y_r           <= '0;
      dec_r         <= DEC_RST;
      frame_start_r <= 1'b0;
    end else begin
      x_r           <= x_next_s;
      y_r           <= y_next_s;
      dec_r         <= dec_next_s;
      frame_start_r <= wrap_s;
    end
  end

  assign p_tick      = p_tick_s;
  assign x           = x_r;
  assign y           = y_r;
  assign frame_start = frame_start_r;

`ifdef VGA_PIPE_EN
  localparam sync_t PIPE_RST = '{hsync: 1'b1, vsync: 1'b1, video_on: 1'b0};

  sync_t pipe1_r;
  sync_t pipe2_r;

  // two-stage delay to line up with the ROM read plus registered rgb
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pipe1_r <= PIPE_RST;
      pipe2_r <= PIPE_RST;
    end else begin
      pipe1_r <= dec_r;
      pipe2_r <= pipe1_r;
    end
  end

  assign hsync    = pipe2_r.hsync;
  assign vsync    = pipe2_r.vsync;
  assign video_on = pipe2_r.video_on;
`else
  assign hsync    = dec_r.hsync;
  assign vsync    = dec_r.vsync;
  assign video_on = dec_r.video_on;
`endif

endmodule
